// File: rtl/sha_core_scheduler.sv
// sha_core_scheduler: shares one mining job across NUM_CORES sha256_double
// cores. Each core gets the same block/midstate/target/position and its own
// nonce slice. The first hit (lowest index on ties), an abort or a timeout
// ends the job. One result record is returned and all cores go back to reset.
//
// Result handshake: res_valid rises with a stable record and stays high with
// all res_* fields held until a cycle where res_valid & res_ready are both
// high. The job side uses the same rule: a job is taken on a cycle where
// job_valid & job_ready are both high.
module sha_core_scheduler #(
    parameter int          NUM_CORES      = 4,
    parameter logic [31:0] NONCE_STRIDE   = 32'h4000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 100_000_000,
    parameter int          RST_CYCLES     = 2
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       job_valid,
    output logic                       job_ready,
    input  logic [511:0]               job_data,
    input  logic [255:0]               job_state,
    input  logic [255:0]               job_target,
    input  logic [31:0]                job_nonce_base,
    input  logic [31:0]                job_position,
    input  logic                       abort,
    output logic [NUM_CORES-1:0]       core_rst,
    output logic [NUM_CORES-1:0]       core_in_valid,
    output logic [511:0]               core_in_data,
    output logic [255:0]               core_in_state,
    output logic [255:0]               core_in_target,
    output logic [31:0]                core_in_position,
    output logic [32*NUM_CORES-1:0]    core_nonce_base,
    input  logic [NUM_CORES-1:0]       core_out_valid,
    input  logic [256*NUM_CORES-1:0]   core_out_result,
    input  logic [32*NUM_CORES-1:0]    core_out_nonce,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [1:0]                 res_status,
    output logic [3:0]                 res_core,
    output logic [31:0]                res_nonce,
    output logic [255:0]               res_hash,
    output logic [2:0]                 dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RESET  = 3'd1,
        S_START  = 3'd2,
        S_RUN    = 3'd3,
        S_REPORT = 3'd4
    } state_t;

    localparam logic [1:0]  STATUS_FOUND   = 2'd0;
    localparam logic [1:0]  STATUS_TIMEOUT = 2'd1;
    localparam logic [1:0]  STATUS_ABORTED = 2'd2;
    localparam logic [15:0] RST_LAST       = 16'(RST_CYCLES - 1);
    localparam logic [31:0] TMO_LAST       = 32'(TIMEOUT_CYCLES - 1);

    state_t        state;
    state_t        next_state;
    logic [15:0]   rst_cnt;
    logic [31:0]   tmo_cnt;
    logic          tmo_hit;
    logic          hit_any;
    logic [3:0]    hit_idx;
    logic [31:0]   hit_nonce;
    logic [255:0]  hit_hash;

    assign dbg_state = state;
    assign hit_any   = |core_out_valid;
    assign tmo_hit   = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST);

    // Lowest-index asserted core wins; its nonce and hash are picked here.
    always_comb begin
        hit_idx   = '0;
        hit_nonce = '0;
        hit_hash  = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (core_out_valid[i]) begin
                hit_idx   = 4'(i);
                hit_nonce = core_out_nonce[32*i +: 32];
                hit_hash  = core_out_result[256*i +: 256];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; job_ready is the only combinational output.
    always_comb begin
        next_state = state;
        job_ready  = 1'b0;
        case (state)
            S_IDLE: begin
                job_ready = 1'b1;
                if (job_valid) next_state = S_RESET;
            end
            S_RESET: begin
                if (rst_cnt == RST_LAST) next_state = S_START;
            end
            S_START: begin
                next_state = S_RUN;
            end
            S_RUN: begin
                if (hit_any || abort || tmo_hit) next_state = S_REPORT;
            end
            S_REPORT: begin
                // res_valid is high for the whole REPORT state.
                if (res_ready) next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Core control strobes are registered from the state being entered so
    // they line up exactly with that state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            core_rst      <= '1;
            core_in_valid <= '0;
        end else begin
            if (next_state == S_START || next_state == S_RUN) begin
                core_rst <= '0;
            end else begin
                core_rst <= '1;
            end
            if (next_state == S_START) begin
                core_in_valid <= '1;
            end else begin
                core_in_valid <= '0;
            end
        end
    end

    // Reset-hold and timeout counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rst_cnt <= '0;
            tmo_cnt <= '0;
        end else begin
            if (state == S_RESET) begin
                rst_cnt <= rst_cnt + 16'd1;
            end else begin
                rst_cnt <= '0;
            end
            if (state == S_START) begin
                tmo_cnt <= '0;
            end else if (state == S_RUN) begin
                tmo_cnt <= tmo_cnt + 32'd1;
            end
        end
    end

    // Job fields and per-core nonce bases are captured on acceptance and held
    // until the next accepted job.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            core_in_data     <= '0;
            core_in_state    <= '0;
            core_in_target   <= '0;
            core_in_position <= '0;
            core_nonce_base  <= '0;
        end else if (state == S_IDLE && job_valid) begin
            core_in_data     <= job_data;
            core_in_state    <= job_state;
            core_in_target   <= job_target;
            core_in_position <= job_position;
            for (int i = 0; i < NUM_CORES; i++) begin
                core_nonce_base[32*i +: 32] <= job_nonce_base + NONCE_STRIDE * 32'(i);
            end
        end
    end

    // Result record: captured on the RUN exit with found > abort > timeout,
    // held through REPORT, and released on the handshake.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            res_valid  <= 1'b0;
            res_status <= '0;
            res_core   <= '0;
            res_nonce  <= '0;
            res_hash   <= '0;
        end else if (state == S_RUN && next_state == S_REPORT) begin
            res_valid <= 1'b1;
            if (hit_any) begin
                res_status <= STATUS_FOUND;
                res_core   <= hit_idx;
                res_nonce  <= hit_nonce;
                res_hash   <= hit_hash;
            end else begin
                res_status <= abort ? STATUS_ABORTED : STATUS_TIMEOUT;
                res_core   <= '0;
                res_nonce  <= '0;
                res_hash   <= '0;
            end
        end else if (state == S_REPORT && res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: doc/sha_core_scheduler.md
Name: sha_core_scheduler

Overview:
- Job scheduler that shares one mining job across NUM_CORES sha256_double instances.
- Each core receives the same block data, midstate, target and position, plus its own slice of the nonce space.
- The scheduler waits for the first core to report a hit, or for a timeout or abort, then returns one result record and puts all cores back into reset.
- Sits between the UART command front-end (job producer and result consumer) and the hashing cores.

Parameters:
- NUM_CORES, 4, number of sha256_double cores scheduled; 1..16.
- NONCE_STRIDE, 32'h4000_0000, nonce offset between consecutive cores.
- TIMEOUT_CYCLES, 100_000_000, RUN cycles before giving up; 0 disables the timeout.
- RST_CYCLES, 2, cycles core_rst is held high before a job start; minimum 1.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- job_valid  in  1  job offered.
- job_ready  out  1  scheduler accepts a job.
- job_data  in  512  64-byte block tail.
- job_state  in  256  SHA midstate.
- job_target  in  256  difficulty target.
- job_nonce_base  in  32  first nonce of the job.
- job_position  in  32  nonce byte position.
- abort  in  1  cancel the running job.
- core_rst  out  NUM_CORES  per-core active-high reset.
- core_in_valid  out  NUM_CORES  per-core start pulse.
- core_in_data / core_in_state / core_in_target / core_in_position  out  512/256/256/32  broadcast registered job fields.
- core_nonce_base  out  32*NUM_CORES  per-core nonce base; core i occupies bits [32i+:32].
- core_out_valid  in  NUM_CORES  per-core hit.
- core_out_result  in  256*NUM_CORES  per-core hash.
- core_out_nonce  in  32*NUM_CORES  per-core found nonce.
- res_valid  out  1  result record valid.
- res_ready  in  1  consumer accepts the result.
- res_status  out  2  0 = found, 1 = timeout, 2 = aborted.
- res_core  out  4  index of the winning core; 0 unless status is found.
- res_nonce  out  32  found nonce; 0 unless status is found.
- res_hash  out  256  found hash; 0 unless status is found.

Behaviour:
- Reset (rstn low, asynchronous) forces the following values:
  - state IDLE.
  - job_ready 1.
  - core_rst all 1.
  - core_in_valid 0.
  - res_valid 0.
  - all res_* fields 0.
  - timeout counter 0.
  - registered job fields 0.
- IDLE:
  - job_ready = 1 and core_rst all 1.
  - On job_valid & job_ready, register all job_* fields and go to RESET.
  - For core i, core_nonce_base[i] = job_nonce_base + i*NONCE_STRIDE, truncated to 32 bits (wraps mod 2^32).
- RESET:
  - job_ready = 0.
  - Hold core_rst all 1 for RST_CYCLES cycles, then go to START.
- START (exactly one cycle):
  - core_rst all 0.
  - core_in_valid all 1 for this cycle only.
  - Clear the timeout counter, then go to RUN.
- RUN: core_rst stays 0 and the counter increments each cycle. Exit conditions:
  - If any core_out_valid is high, latch the lowest-index asserted core and go to REPORT with status found. res_core is that index; res_nonce and res_hash are taken from that core's slice in the same cycle.
  - Else if abort is high, go to REPORT with status aborted.
  - Else if TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES-1, go to REPORT with status timeout.
  - Priority is found > abort > timeout. A hit in the same cycle as abort or timeout reports found.
- REPORT:
  - core_rst all 1 from the first REPORT cycle.
  - res_valid = 1 and res_* fields held stable.
  - On res_valid & res_ready, drop res_valid and go to IDLE. job_ready returns to 1 on the next cycle.
  - core_out_valid is ignored in REPORT.
- abort outside RUN is ignored, including an abort during RESET or START.
- job_valid outside IDLE is ignored; job_ready is 0 in every other state.
- core_out_valid seen during RESET or START is ignored; cores are not yet running.
- Latency:
  - Job acceptance to core_in_valid pulse: RST_CYCLES+1 cycles.
  - Hit to res_valid: 1 cycle.
- Every output except combinational job_ready is registered.
- core_in_* broadcast fields and core_nonce_base stay stable from acceptance until the next job acceptance.

Test Plan:
- Basic hit:
  - Stimulus: NUM_CORES=4, job_nonce_base=0x0000_0010; core 2 asserts out_valid with nonce 0x8000_0123.
  - Response: core_nonce_base = {0xC000_0010, 0x8000_0010, 0x4000_0010, 0x0000_0010}; one core_in_valid pulse 3 cycles after acceptance; res_status=0, res_core=2, res_nonce=0x8000_0123; core_rst all 1 on the cycle res_valid rises.
- Simultaneous hits:
  - Stimulus: cores 1 and 3 assert out_valid in the same cycle.
  - Response: res_core=1 with core 1's nonce and hash.
- Nonce wrap:
  - Stimulus: job_nonce_base=0xF000_0000.
  - Response: core_nonce_base[1]=0x3000_0000, [2]=0x7000_0000, [3]=0xB000_0000.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=50, no hit.
  - Response: res_valid rises after 50 RUN cycles with res_status=1 and res_nonce=0.
- Abort and backpressure:
  - Stimulus: abort in RUN and a hit in the same cycle; then hold res_ready=0 for 10 cycles.
  - Response: status found; res_* stable for all 10 cycles; job_valid is ignored until IDLE. A separate abort-only case reports status 2.
- Reset mid-job:
  - Stimulus: drop rstn during RUN.
  - Response: immediately res_valid=0, core_rst all 1, job_ready=1; after release, a new job proceeds normally.
